// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ALU_SHARE_FLAGS_EN adds registered rsp_zero/rsp_carry flag outputs.
module alu_share_ctrl #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [2:0] req0_op,
    input  logic [2:0] req1_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    input  logic [8:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [8:0] rsp_data,
`ifdef ALU_SHARE_FLAGS_EN
    output logic       rsp_zero,
    output logic       rsp_carry,
`endif
    output logic       rsp_id
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic   prio;
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_en     = state == EXEC;
        rsp_valid  = state == RESP;
        case (state)
            IDLE: begin
                // prio=1 means requester 1 wins a tie
                req1_ready = req1_valid && (!req0_valid || prio);
                req0_ready = req0_valid && !req1_ready;
                state_nxt  = (req0_valid || req1_valid) ? EXEC : IDLE;
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= RR_INIT;
            alu_op   <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
`ifdef ALU_SHARE_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (req0_ready || req1_ready) begin
                alu_op  <= req1_ready ? req1_op : req0_op;
                alu_in1 <= req1_ready ? req1_a : req0_a;
                alu_in2 <= req1_ready ? req1_b : req0_b;
                rsp_id  <= req1_ready;
                prio    <= !req1_ready;
            end
            if (state == EXEC) begin
                rsp_data <= alu_out;
`ifdef ALU_SHARE_FLAGS_EN
                rsp_zero  <= alu_out[7:0] == 8'h00;
                rsp_carry <= alu_out[8];
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_share_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       alu_en;
    logic [2:0] alu_op;
    logic [7:0] alu_in1, alu_in2;
    logic [8:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [8:0] rsp_data;
    logic       rsp_id;
`ifdef ALU_SHARE_FLAGS_EN
    logic       rsp_zero, rsp_carry;
`endif
    int tests = 0, errs = 0, en_cnt = 0;

    alu_share_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_en(alu_en), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
`ifdef ALU_SHARE_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
`endif
        .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a} + 9'd1;
            3'd3:    return {1'b0, a} - 9'd1;
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return {1'b0, a ^ b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_op, alu_in1, alu_in2);
    always @(negedge clk) if (alu_en) en_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk) #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_op(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int stall, input logic [8:0] exp);
        int n = 0;
        @(posedge clk) #1;
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        rsp_ready = stall == 0;
        do @(negedge clk); while (!(id ? req1_ready : req0_ready) && ++n < 20);
        chk("accept", id ? req1_ready : req0_ready, 1);
        @(posedge clk) #1 begin req0_valid = 0; req1_valid = 0; end
        @(negedge clk);
        chk("exec_en", alu_en, 1);
        chk("exec_no_rsp", rsp_valid, 0);
        chk("exec_op", {alu_op, alu_in1, alu_in2}, {op, a, b});
        @(negedge clk);
        chk("lat_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp);
        chk("rsp_id", rsp_id, id);
`ifdef ALU_SHARE_FLAGS_EN
        chk("rsp_zero", rsp_zero, exp[7:0] == 8'h00);
        chk("rsp_carry", rsp_carry, exp[8]);
`endif
        for (int i = 0; i < stall; i++) begin
            @(posedge clk) #1 begin req0_valid = 1; req1_valid = 1; end
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, exp);
            chk("stall_no_rdy", {req0_ready, req1_ready}, 0);
        end
        if (stall > 0) @(posedge clk) #1 rsp_ready = 1;
        @(posedge clk) #1 begin rsp_ready = 0; req0_valid = 0; req1_valid = 0; end
        @(negedge clk);
        chk("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        int n, t, g, cyc_ok;
        bit free, prio, acc0, acc1;
        logic [9:0] q[$];
        // reset values
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_alu", {alu_en, alu_op, alu_in1, alu_in2}, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);

        // round-robin with both requesters pending from reset release
        req0_valid = 1; req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd2;
        req1_valid = 1; req1_op = 3'd1; req1_a = 8'd9; req1_b = 8'd4;
        rsp_ready = 1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do @(negedge clk); while (!(req0_ready || req1_ready) && ++n < 20);
            if (k == 0) chk("first_grant_lat", n, 0);
            chk("rr_grant", {req0_ready, req1_ready}, (k % 2) ? 2'b01 : 2'b10);
            n = 0;
            do @(negedge clk); while (!rsp_valid && ++n < 20);
            chk("rr_rsp_id", rsp_id, k % 2);
            chk("rr_rsp_data", rsp_data, (k % 2) ? 9'd5 : 9'd3);
        end
        @(posedge clk) #1 begin req0_valid = 0; req1_valid = 0; rsp_ready = 0; end
        @(negedge clk);

        run_op(0, 3'd0, 8'hF0, 8'h20, 0, 9'h110);
        run_op(1, 3'd6, 8'h5A, 8'h5A, 5, 9'h000);
        @(posedge clk) #1 en_cnt = 0;
        run_op(1, 3'd1, 8'h05, 8'h07, 0, 9'h1FE);
        run_op(1, 3'd2, 8'hFF, 8'h00, 0, 9'h100);
        run_op(1, 3'd3, 8'h00, 8'h00, 0, 9'h1FF);
        @(posedge clk) #1 chk("en_cycles", en_cnt, 3);

        // reset while executing discards the operation
        req0_valid = 1; req0_op = 3'd7; req0_a = 8'h33; rsp_ready = 1;
        n = 0;
        do @(negedge clk); while (!req0_ready && ++n < 20);
        @(posedge clk) #1 begin rst_n = 0; req0_valid = 0; end
        #1;
        chk("rst_exec_en", alu_en, 0);
        chk("rst_exec_valid", rsp_valid, 0);
        @(posedge clk) #1 rst_n = 1;
        cyc_ok = 0;
        repeat (5) begin @(negedge clk); cyc_ok += rsp_valid | alu_en; end
        chk("rst_no_rsp", cyc_ok, 0);

        // randomized traffic against a transaction-level model
        rsp_ready = 0;
        do_reset();
        free = 1; prio = 0; t = 0; acc0 = 0; acc1 = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk) #1;
            if (!req0_valid || acc0) begin
                req0_valid = $urandom_range(9) < 6; req0_op = 3'($urandom);
                req0_a = 8'($urandom); req0_b = 8'($urandom);
            end else if ($urandom_range(19) == 0) req0_valid = 0;
            if (!req1_valid || acc1) begin
                req1_valid = $urandom_range(9) < 6; req1_op = 3'($urandom);
                req1_a = 8'($urandom); req1_b = 8'($urandom);
            end else if ($urandom_range(19) == 0) req1_valid = 0;
            rsp_ready = $urandom_range(2) != 0;
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (free) begin
                chk("r_idle_valid", rsp_valid, 0);
                if (req0_valid || req1_valid) begin
                    g = (req0_valid && req1_valid) ? int'(prio) : int'(req1_valid);
                    chk("r_grant", {req0_ready, req1_ready}, g ? 2'b01 : 2'b10);
                    q.push_back(g ? {1'b1, alu_f(req1_op, req1_a, req1_b)} : {1'b0, alu_f(req0_op, req0_a, req0_b)});
                    prio = (g == 0);
                    free = 0;
                    t = 0;
                end else chk("r_no_grant", {req0_ready, req1_ready}, 0);
            end else begin
                t++;
                chk("r_busy_no_rdy", {req0_ready, req1_ready}, 0);
                chk("r_alu_en", alu_en, t == 1);
                chk("r_rsp_valid", rsp_valid, t >= 2);
                if (t >= 2 && q.size() > 0) begin
                    chk("r_rsp", {rsp_id, rsp_data}, q[0]);
                    if (rsp_ready) begin void'(q.pop_front()); free = 1; end
                end
            end
        end
        @(posedge clk) #1 begin req0_valid = 0; req1_valid = 0; rsp_ready = 1; end
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 SHALL have parameter RR_INIT, default 0: requester holding round-robin priority after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester k has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester k's operation accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  3  ALU opcode (000 add, 001 sub, 010 inc, 011 dec, 100 and, 101 or, 110 xor, 111 not).
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  8  operands.
REQ-008 SHALL have port alu_en  output  1  ALU enable.
REQ-009 SHALL have ports alu_op  output  3, alu_in1 / alu_in2  output  8  ALU operation and operands.
REQ-010 SHALL have port alu_out  input  9  ALU combinational result, bit 8 = carry/borrow.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  9, rsp_id  output  1  (requester number).

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP; a req/rsp handshake completes when valid and ready are both high at a rising edge.
REQ-013 IDLE: if any reqk_valid, SHALL grant one requester, assert only its reqk_ready (combinationally, IDLE only), latch op/a/b and id, go to EXEC.
REQ-014 SHALL grant the priority requester when both valid; the only valid requester when one valid; after every grant, priority SHALL pass to the other requester.
REQ-015 EXEC (exactly one cycle): alu_en=1, alu_op/alu_in1/alu_in2 driven from latched values; at the closing edge SHALL capture alu_out into rsp_data, go to RESP.
REQ-016 RESP: rsp_valid=1, rsp_data/rsp_id stable; SHALL stay in RESP until rsp_ready=1, then go to IDLE.
REQ-017 alu_en SHALL be 0 outside EXEC; alu_op/alu_in1/alu_in2 SHALL hold last latched values.
REQ-018 reqk_ready SHALL be 0 in EXEC and RESP; requests arriving there wait, no drop.
REQ-019 Minimum latency: accept edge to rsp_valid = 2 cycles; max throughput 1 op per 3 cycles with rsp_ready held high.
REQ-020 rsp_data SHALL be the unmodified 9-bit alu_out; no width extension or truncation in this block.
REQ-021 A reqk_valid deassertion without handshake SHALL cancel nothing already accepted and cause no grant.

Reset
REQ-022 On rst_n low, state SHALL go to IDLE immediately, including mid-EXEC/RESP; in-flight operation is discarded.
REQ-023 Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, alu_en=0, alu_op=0, alu_in1=0, alu_in2=0, reqk_ready=0, priority=RR_INIT.
REQ-024 First grant SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-025 With ALU_SHARE_FLAGS_EN defined, SHALL add outputs rsp_zero (1: rsp_data[7:0]==0) and rsp_carry (=rsp_data[8]), captured with rsp_data, reset to 0.
REQ-026 Without ALU_SHARE_FLAGS_EN, rsp_zero and rsp_carry SHALL not exist; all other behaviour identical.

Verification
REQ-027 req0 add a=8'hF0 b=8'h20, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=9'h110, rsp_id=0, rsp_carry=1 (flags on).
REQ-028 req0 and req1 valid continuously, RR_INIT=0 -> grants 0,1,0,1; each rsp_id matches granted requester.
REQ-029 req1 xor a=8'h5A b=8'h5A, rsp_ready=0 for 5 cycles -> rsp_data=0 held, rsp_zero=1, no reqk_ready; completes on rsp_ready=1.
REQ-030 rst_n low during EXEC -> alu_en=0, rsp_valid=0 immediately; no response after release.
REQ-031 Only req1 valid, three ops (sub 8'h05-8'h07, inc 8'hFF, dec 8'h00) -> rsp_data 9'h1FE, 9'h100, 9'h1FF; alu_en high exactly one cycle per op.
